// File: rtl/dds_multich_core_if.sv
// rtl/dds_multich_core_if.sv - register write port bundle for dds_multich_core
interface dds_multich_core_if;
  logic        wr_en;
  logic [2:0]  wr_ch;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;

  modport master (output wr_en, output wr_ch, output wr_addr, output wr_data);
  modport slave  (input wr_en, input wr_ch, input wr_addr, input wr_data);
endinterface

// File: rtl/dds_multich_core.sv
// rtl/dds_multich_core.sv - N-channel DDS engine with shadowed registers and atomic commit
// Per channel: accumulator -> phase/wave -> amplitude scale -> bias + saturate, 3-cycle latency.
module dds_multich_core #(
  parameter int NUM_CH = 2,
  parameter int ACC_W  = 32,
  parameter int DAC_W  = 14,
  parameter int LUT_AW = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  dds_multich_core_if.slave        wr,
  output logic [NUM_CH*LUT_AW-1:0] rom_addr,
  input  logic [NUM_CH*DAC_W-1:0]  rom_data,
  output logic [NUM_CH*DAC_W-1:0]  dac_data,
  output logic                     dac_valid
);

  localparam logic [2:0] A_FREQ   = 3'd0;
  localparam logic [2:0] A_PHASE  = 3'd1;
  localparam logic [2:0] A_AMP    = 3'd2;
  localparam logic [2:0] A_WAVE   = 3'd3;
  localparam logic [2:0] A_BIAS   = 3'd4;
  localparam logic [2:0] A_DUTY   = 3'd5;
  localparam logic [2:0] A_CTRL   = 3'd6;
  localparam logic [2:0] A_COMMIT = 3'd7;

  localparam logic [2:0] W_SINE   = 3'd0;
  localparam logic [2:0] W_SQUARE = 3'd1;
  localparam logic [2:0] W_TRI    = 3'd2;
  localparam logic [2:0] W_SAW    = 3'd3;
  localparam logic [2:0] W_PWM    = 3'd4;

  localparam logic [DAC_W-1:0] P_MAX = {1'b0, {(DAC_W-1){1'b1}}};
  localparam logic [DAC_W-1:0] N_MAX = {1'b1, {(DAC_W-2){1'b0}}, 1'b1};
  localparam logic [DAC_W-1:0] MID   = {1'b1, {(DAC_W-1){1'b0}}};

  logic [1:0] r_prime;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prime <= 2'd0;
    end else if (r_prime != 2'd3) begin
      r_prime <= r_prime + 2'd1;
    end
  end

  assign dac_valid = (r_prime == 2'd3);

  wire w_commit = wr.wr_en && (wr.wr_addr == A_COMMIT);
  wire w_sync   = wr.wr_data[31];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [2:0] CH = 3'(g);

    wire w_sel  = wr.wr_en && (wr.wr_ch == CH) && (wr.wr_addr != A_COMMIT);
    wire w_take = w_commit && wr.wr_data[g];

    logic [ACC_W-1:0] r_sh_freq, r_sh_phase, r_act_freq, r_act_phase;
    logic [4:0]       r_sh_amp, r_act_amp;
    logic [2:0]       r_sh_wave, r_act_wave;
    logic [DAC_W-1:0] r_sh_bias, r_act_bias;
    logic [7:0]       r_sh_duty, r_act_duty;
    logic             r_sh_en, r_act_en;

    logic [ACC_W-1:0]  r_acc;
    logic [LUT_AW-1:0] r_rom_addr;
    logic [DAC_W-1:0]  r_w1;
    logic              r_sine1;
    logic [4:0]        r_amp1;
    logic [DAC_W-1:0]  r_bias1;
    logic [DAC_W+1:0]  r_s2;
    logic [DAC_W-1:0]  r_bias2;
    logic [DAC_W-1:0]  r_dac;

    logic [ACC_W-1:0] w_p;
    logic [DAC_W-1:0] w_t;
    logic [DAC_W-1:0] w_wave;
    logic [DAC_W-1:0] w_src;
    logic [DAC_W+5:0] w_prod;
    logic [DAC_W+6:0] w_y;
    logic [DAC_W-1:0] w_sat;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sh_freq  <= '0;
        r_sh_phase <= '0;
        r_sh_amp   <= '0;
        r_sh_wave  <= '0;
        r_sh_bias  <= '0;
        r_sh_duty  <= '0;
        r_sh_en    <= 1'b0;
      end else if (w_sel) begin
        case (wr.wr_addr)
          A_FREQ:  r_sh_freq  <= wr.wr_data[ACC_W-1:0];
          A_PHASE: r_sh_phase <= wr.wr_data[ACC_W-1:0];
          A_AMP:   r_sh_amp   <= wr.wr_data[4:0];
          A_WAVE:  r_sh_wave  <= wr.wr_data[2:0];
          A_BIAS:  r_sh_bias  <= wr.wr_data[DAC_W-1:0];
          A_DUTY:  r_sh_duty  <= wr.wr_data[7:0];
          A_CTRL:  r_sh_en    <= wr.wr_data[0];
          default: ;
        endcase
      end
    end

    // The whole shadow set moves in one edge so multi-field updates never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_act_freq  <= '0;
        r_act_phase <= '0;
        r_act_amp   <= '0;
        r_act_wave  <= '0;
        r_act_bias  <= '0;
        r_act_duty  <= '0;
        r_act_en    <= 1'b0;
      end else if (w_take) begin
        r_act_freq  <= r_sh_freq;
        r_act_phase <= r_sh_phase;
        r_act_amp   <= r_sh_amp;
        r_act_wave  <= r_sh_wave;
        r_act_bias  <= r_sh_bias;
        r_act_duty  <= r_sh_duty;
        r_act_en    <= r_sh_en;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_acc <= '0;
      end else if (w_take && w_sync) begin
        r_acc <= '0;
      end else if (r_act_en) begin
        r_acc <= r_acc + r_act_freq;
      end else begin
        r_acc <= '0;
      end
    end

    always_comb begin
      w_p    = r_acc + r_act_phase;
      w_t    = w_p[ACC_W-2 -: DAC_W];
      w_wave = '0;
      if (r_act_en) begin
        case (r_act_wave)
          W_SQUARE: w_wave = w_p[ACC_W-1] ? N_MAX : P_MAX;
          W_TRI:    w_wave = w_p[ACC_W-1] ? (~w_t - MID) : (w_t - MID);
          W_SAW:    w_wave = {~w_p[ACC_W-1], w_p[ACC_W-2 -: DAC_W-1]};
          W_PWM:    w_wave = (w_p[ACC_W-1 -: 8] < r_act_duty) ? P_MAX : N_MAX;
          default:  w_wave = '0;
        endcase
      end
    end

    // Scale, bias and sine-select travel with the sample so a commit lands on one coherent sample.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rom_addr <= '0;
        r_w1       <= '0;
        r_sine1    <= 1'b0;
        r_amp1     <= '0;
        r_bias1    <= '0;
      end else begin
        r_rom_addr <= w_p[ACC_W-1 -: LUT_AW];
        r_w1       <= w_wave;
        r_sine1    <= r_act_en && (r_act_wave == W_SINE);
        r_amp1     <= r_act_amp;
        r_bias1    <= r_act_bias;
      end
    end

    always_comb begin
      w_src  = r_sine1 ? rom_data[g*DAC_W +: DAC_W] : r_w1;
      w_prod = {{6{w_src[DAC_W-1]}}, w_src} * {{(DAC_W+1){1'b0}}, r_amp1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s2    <= '0;
        r_bias2 <= '0;
      end else begin
        r_s2    <= w_prod[DAC_W+5:4];
        r_bias2 <= r_bias1;
      end
    end

    always_comb begin
      w_y = {{5{r_s2[DAC_W+1]}}, r_s2} + {{7{r_bias2[DAC_W-1]}}, r_bias2} + {7'd0, MID};
      if (w_y[DAC_W+6]) begin
        w_sat = '0;
      end else if (|w_y[DAC_W+5:DAC_W]) begin
        w_sat = '1;
      end else begin
        w_sat = w_y[DAC_W-1:0];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_dac <= MID;
      end else begin
        r_dac <= w_sat;
      end
    end

    assign rom_addr[g*LUT_AW +: LUT_AW] = r_rom_addr;
    assign dac_data[g*DAC_W +: DAC_W]   = r_dac;
  end

endmodule

// File: tb/tb_dds_multich_core.sv
// tb/tb_dds_multich_core.sv - randomized self-checking bench for dds_multich_core
module tb_dds_multich_core;
  localparam int NCH = 2;

  logic        clk;
  logic        rst_n;
  logic [19:0] rom_addr;
  logic [27:0] rom_data;
  logic [27:0] dac_data;
  logic        dac_valid;

  dds_multich_core_if bus ();

  dds_multich_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr        (bus),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .dac_data  (dac_data),
    .dac_valid (dac_valid)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  int rom_tab [NCH][1024];

  always @(negedge clk) begin
    for (int ch = 0; ch < NCH; ch++) rom_data[ch*14 +: 14] = 14'(rom_tab[ch][rom_addr[ch*10 +: 10]]);
  end

  logic [31:0] sh_freq [NCH], sh_phase [NCH], a_freq [NCH], a_phase [NCH], m_acc [NCH];
  logic [4:0]  sh_amp [NCH], a_amp [NCH];
  logic [2:0]  sh_wave [NCH], a_wave [NCH];
  logic [13:0] sh_bias [NCH], a_bias [NCH];
  logic [7:0]  sh_duty [NCH], a_duty [NCH];
  logic        sh_en [NCH], a_en [NCH];
  logic [13:0] pipe_a [NCH], pipe_b [NCH];
  int          vcnt;
  int          n_checks, n_pass;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      sh_freq[ch] = 0; sh_phase[ch] = 0; sh_amp[ch] = 0; sh_wave[ch] = 0;
      sh_bias[ch] = 0; sh_duty[ch] = 0; sh_en[ch] = 0;
      a_freq[ch] = 0; a_phase[ch] = 0; a_amp[ch] = 0; a_wave[ch] = 0;
      a_bias[ch] = 0; a_duty[ch] = 0; a_en[ch] = 0;
      m_acc[ch] = 0; pipe_a[ch] = 14'h2000; pipe_b[ch] = 14'h2000;
    end
    vcnt = 0;
  endtask

  function automatic logic [13:0] exp_sample(input int ch);
    logic [31:0] p;
    int w, t, s, b, y;
    p = m_acc[ch] + a_phase[ch];
    t = int'(p[30:17]);
    w = 0;
    if (a_en[ch]) begin
      case (a_wave[ch])
        3'd0: w = rom_tab[ch][p[31:22]];
        3'd1: w = p[31] ? -8191 : 8191;
        3'd2: w = p[31] ? 8191 - t : t - 8192;
        3'd3: w = int'(p[31:18]) - 8192;
        3'd4: w = (int'(p[31:24]) < int'(a_duty[ch])) ? 8191 : -8191;
        default: w = 0;
      endcase
    end
    s = (w * int'(a_amp[ch])) >>> 4;
    b = int'(a_bias[ch]);
    if (b >= 8192) b = b - 16384;
    y = s + b + 8192;
    if (y < 0) y = 0;
    else if (y > 16383) y = 16383;
    return y[13:0];
  endfunction

  task automatic model_edge();
    logic commit;
    commit = bus.wr_en && (bus.wr_addr == 3'd7);
    for (int ch = 0; ch < NCH; ch++) begin
      if (commit && bus.wr_data[ch] && bus.wr_data[31]) m_acc[ch] = 0;
      else if (a_en[ch]) m_acc[ch] = m_acc[ch] + a_freq[ch];
      else m_acc[ch] = 0;
      if (commit && bus.wr_data[ch]) begin
        a_freq[ch] = sh_freq[ch]; a_phase[ch] = sh_phase[ch]; a_amp[ch] = sh_amp[ch];
        a_wave[ch] = sh_wave[ch]; a_bias[ch] = sh_bias[ch]; a_duty[ch] = sh_duty[ch];
        a_en[ch] = sh_en[ch];
      end else if (bus.wr_en && !commit && int'(bus.wr_ch) == ch) begin
        case (bus.wr_addr)
          3'd0: sh_freq[ch] = bus.wr_data;
          3'd1: sh_phase[ch] = bus.wr_data;
          3'd2: sh_amp[ch] = bus.wr_data[4:0];
          3'd3: sh_wave[ch] = bus.wr_data[2:0];
          3'd4: sh_bias[ch] = bus.wr_data[13:0];
          3'd5: sh_duty[ch] = bus.wr_data[7:0];
          default: sh_en[ch] = bus.wr_data[0];
        endcase
      end
    end
  endtask

  task automatic tick();
    logic [13:0] s_new [NCH];
    logic [9:0]  r_new [NCH];
    logic [31:0] p;
    for (int ch = 0; ch < NCH; ch++) begin
      s_new[ch] = exp_sample(ch);
      p = m_acc[ch] + a_phase[ch];
      r_new[ch] = p[31:22];
    end
    model_edge();
    @(posedge clk);
    #1;
    if (vcnt < 3) vcnt++;
    for (int ch = 0; ch < NCH; ch++) begin
      chk($sformatf("dac_data ch%0d", ch), 32'(dac_data[ch*14 +: 14]), 32'(pipe_b[ch]));
      chk($sformatf("rom_addr ch%0d", ch), 32'(rom_addr[ch*10 +: 10]), 32'(r_new[ch]));
      pipe_b[ch] = pipe_a[ch];
      pipe_a[ch] = s_new[ch];
    end
    chk("dac_valid", 32'(dac_valid), 32'(vcnt >= 3));
  endtask

  task automatic wr(input logic [2:0] addr, input logic [2:0] ch, input logic [31:0] data);
    bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_ch = ch; bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic chk_reset_state();
    for (int ch = 0; ch < NCH; ch++) begin
      chk($sformatf("reset dac ch%0d", ch), 32'(dac_data[ch*14 +: 14]), 32'h2000);
      chk($sformatf("reset rom ch%0d", ch), 32'(rom_addr[ch*10 +: 10]), 32'h0);
    end
    chk("reset dac_valid", 32'(dac_valid), 32'h0);
  endtask

  initial begin
    int hi;
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_ch = 3'd0; bus.wr_addr = 3'd0; bus.wr_data = 32'd0;
    rom_data = '0;
    for (int ch = 0; ch < NCH; ch++)
      for (int i = 0; i < 1024; i++) rom_tab[ch][i] = int'($urandom_range(16383)) - 8192;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state();
    rst_n = 1'b1;
    repeat (6) tick();

    // sawtooth on ch0, ch1 idle
    wr(3'd0, 3'd0, 32'h0100_0000);
    wr(3'd3, 3'd0, 32'd3);
    wr(3'd2, 3'd0, 32'd16);
    wr(3'd4, 3'd0, 32'd0);
    wr(3'd6, 3'd0, 32'd1);
    wr(3'd7, 3'd0, 32'h1);
    repeat (300) tick();

    // shadow isolation, then commit halves amplitude
    wr(3'd2, 3'd0, 32'd8);
    repeat (12) tick();
    wr(3'd7, 3'd0, 32'h1);
    repeat (12) tick();

    // phase-aligned sine restart on both channels
    for (int ch = 0; ch < NCH; ch++) begin
      wr(3'd0, 3'(ch), 32'h0123_4567);
      wr(3'd3, 3'(ch), 32'd0);
      wr(3'd2, 3'(ch), 32'd16);
      wr(3'd6, 3'(ch), 32'd1);
    end
    wr(3'd1, 3'd1, 32'h4000_0000);
    wr(3'd7, 3'd0, 32'h8000_0003);
    repeat (50) tick();

    // saturation at both rails
    wr(3'd3, 3'd0, 32'd1);
    wr(3'd2, 3'd0, 32'd31);
    wr(3'd4, 3'd0, 32'h1000);
    wr(3'd7, 3'd0, 32'h1);
    repeat (300) tick();
    wr(3'd4, 3'd0, 32'h2000);
    wr(3'd7, 3'd0, 32'h1);
    repeat (300) tick();

    // PWM duty 64 then duty 0
    wr(3'd0, 3'd0, 32'h0100_0000);
    wr(3'd3, 3'd0, 32'd4);
    wr(3'd5, 3'd0, 32'd64);
    wr(3'd2, 3'd0, 32'd16);
    wr(3'd4, 3'd0, 32'd0);
    wr(3'd7, 3'd0, 32'h1);
    repeat (4) tick();
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (dac_data[13:0] == 14'h3FFF) hi++;
    end
    chk("pwm duty64 high count", 32'(hi), 32'd64);
    wr(3'd5, 3'd0, 32'd0);
    wr(3'd7, 3'd0, 32'h1);
    repeat (4) tick();
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (dac_data[13:0] == 14'h3FFF) hi++;
    end
    chk("pwm duty0 high count", 32'(hi), 32'd0);

    // randomized configurations, including writes to absent channels
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < 6; k++) wr(3'($urandom_range(6)), 3'($urandom_range(7)), $urandom());
      wr(3'd3, 3'd0, 32'(it % 8));
      wr(3'd3, 3'd1, 32'($urandom_range(7)));
      for (int ch = 0; ch < NCH; ch++) begin
        wr(3'd0, 3'(ch), $urandom());
        wr(3'd6, 3'(ch), 32'($urandom_range(4) != 0));
      end
      wr(3'd7, 3'($urandom_range(7)), {1'($urandom_range(1)), 29'($urandom()), 2'($urandom_range(3))});
      repeat ($urandom_range(20, 60)) tick();
    end

    // reset mid-operation loses shadow contents
    rst_n = 1'b0;
    #1;
    chk_reset_state();
    rst_n = 1'b1;
    model_reset();
    wr(3'd7, 3'd0, 32'h3);
    repeat (10) tick();
    wr(3'd0, 3'd1, 32'h0300_0000);
    wr(3'd3, 3'd1, 32'd2);
    wr(3'd2, 3'd1, 32'd20);
    wr(3'd4, 3'd1, 32'h3F00);
    wr(3'd6, 3'd1, 32'd1);
    wr(3'd7, 3'd0, 32'h8000_0002);
    repeat (40) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
